// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running line/frame counters, same-cycle pixel request
// decode, and a sync/enable delay line matched to the pixel source latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_FP     = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter int V_FP     = 10,
    parameter int SYNC_POL = 0,
    parameter int PIPE     = 2,
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2,
    parameter int CW       = 10
) (
    input  logic          dclk,
    input  logic          clr,
    input  logic [RW-1:0] red_in,
    input  logic [GW-1:0] green_in,
    input  logic [BW-1:0] blue_in,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          req_active,
    output logic          frame_start,
    output logic          line_start,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [RW-1:0] red,
    output logic [GW-1:0] green,
    output logic [BW-1:0] blue,
    output logic [7:0]    frame_cnt
);

    localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW = $clog2(HT + 1);
    localparam int VW = $clog2(VT + 1);

    localparam logic [HW-1:0] H_LAST     = HW'(HT - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] HA_START   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] HA_END     = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] VA_START   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] VA_END     = VW'(V_SYNC + V_BP + V_ACTIVE);

    localparam logic       SP       = (SYNC_POL != 0);
    localparam logic [2:0] CTL_IDLE = {~SP, ~SP, 1'b0};

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          h_act;
    logic          v_act;
    logic          hs_raw;
    logic          vs_raw;
    logic [2:0]    ctl_raw;
    logic [2:0]    ctl_p [0:PIPE];
    logic          de_tap;

    // Counter stage: hc wraps every line, vc advances only on the hc wrap.
    always_ff @(posedge dclk) begin
        if (clr) begin
            hc        <= '0;
            vc        <= '0;
            frame_cnt <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            if (vc == V_LAST) begin
                vc        <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                vc <= vc + VW'(1);
            end
        end else begin
            hc <= hc + HW'(1);
        end
    end

    // Request decode, combinational from the counters so the pixel source sees it at once.
    assign h_act       = (hc >= HA_START) && (hc < HA_END);
    assign v_act       = (vc >= VA_START) && (vc < VA_END);
    assign req_active  = h_act && v_act;
    assign x           = req_active ? CW'(hc - HA_START) : '0;
    assign y           = req_active ? CW'(vc - VA_START) : '0;
    assign line_start  = (hc == '0);
    assign frame_start = (hc == '0) && (vc == '0);

    assign hs_raw  = (hc < H_SYNC_END) ? SP : ~SP;
    assign vs_raw  = (vc < V_SYNC_END) ? SP : ~SP;
    assign ctl_raw = {hs_raw, vs_raw, req_active};

    // Delay line stages p0..pPIPE carry {hsync, vsync, de} already at output polarity.
    always_ff @(posedge dclk) begin
        if (clr) begin
            for (int i = 0; i <= PIPE; i++) begin
                ctl_p[i] <= CTL_IDLE;
            end
        end else begin
            ctl_p[0] <= ctl_raw;
            for (int i = 1; i <= PIPE; i++) begin
                ctl_p[i] <= ctl_p[i-1];
            end
        end
    end

    generate
        if (PIPE == 0) begin : g_tap_raw
            assign de_tap = req_active;
        end else begin : g_tap_dly
            assign de_tap = ctl_p[PIPE-1][0];
        end
    endgenerate

    assign hsync = ctl_p[PIPE][2];
    assign vsync = ctl_p[PIPE][1];
    assign de    = ctl_p[PIPE][0];

    // Colour stage: the source data arrives PIPE cycles after the request, so it is
    // qualified by de tapped PIPE stages down and lands in step with the last stage.
    always_ff @(posedge dclk) begin
        if (clr || !de_tap) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= red_in;
            green <= green_in;
            blue  <= blue_in;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: instance a uses default horizontal timing with a short frame,
// instance b the tiny active-high PIPE=0 raster used for the frame counter wrap.
module tb_vga_timing_gen;

    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s n=%0d: got %0d expected %0d", name, n, act, exp);
        end
    endtask

    // ---------------- instance a: PIPE=2, active-low, V 4/2/3/1 ----------------
    logic       clr_a;
    logic [2:0] red_in_a, green_in_a, red_a, green_a;
    logic [1:0] blue_in_a, blue_a;
    logic [9:0] x_a, y_a;
    logic       req_a, fs_a, ls_a, hs_a, vs_a, de_a;
    logic [7:0] fc_a;

    vga_timing_gen #(.V_ACTIVE(4), .V_SYNC(2), .V_BP(3), .V_FP(1)) dut_a (
        .dclk(dclk), .clr(clr_a),
        .red_in(red_in_a), .green_in(green_in_a), .blue_in(blue_in_a),
        .x(x_a), .y(y_a), .req_active(req_a), .frame_start(fs_a), .line_start(ls_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .red(red_a), .green(green_a), .blue(blue_a), .frame_cnt(fc_a)
    );

    // ---------------- instance b: PIPE=0, active-high, H 4/2/2/2, V 3/1/1/1 ----------------
    logic       clr_b;
    logic [2:0] red_in_b, green_in_b, red_b, green_b;
    logic [1:0] blue_in_b, blue_b;
    logic [9:0] x_b, y_b;
    logic       req_b, fs_b, ls_b, hs_b, vs_b, de_b;
    logic [7:0] fc_b;

    vga_timing_gen #(.H_ACTIVE(4), .H_SYNC(2), .H_BP(2), .H_FP(2),
                     .V_ACTIVE(3), .V_SYNC(1), .V_BP(1), .V_FP(1),
                     .SYNC_POL(1), .PIPE(0)) dut_b (
        .dclk(dclk), .clr(clr_b),
        .red_in(red_in_b), .green_in(green_in_b), .blue_in(blue_in_b),
        .x(x_b), .y(y_b), .req_active(req_b), .frame_start(fs_b), .line_start(ls_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .red(red_b), .green(green_b), .blue(blue_b), .frame_cnt(fc_b)
    );

    // Scoreboards: expected colours pushed when a pixel is requested, from bench-side counters.
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [9:0] ex_xa = '0, ex_ya = '0, ex_xb = '0, ex_yb = '0;

    // Pixel source a: colour is a function of the requested x/y, returned 2 cycles later;
    // all-ones during blanking so any leak past de shows up.
    initial begin : src_a
        logic [7:0] c, p1, p2;
        p1 = 8'hFF;
        p2 = 8'hFF;
        {red_in_a, green_in_a, blue_in_a} = 8'hFF;
        forever begin
            @(negedge dclk);
            c = (req_a === 1'b1) ? {x_a[2:0], y_a[2:0], x_a[4:3]} : 8'hFF;
            {red_in_a, green_in_a, blue_in_a} = p2;
            p2 = p1;
            p1 = c;
            if (!clr_a && req_a === 1'b1) begin
                q_a.push_back({ex_xa[2:0], ex_ya[2:0], ex_xa[4:3]});
                if (ex_xa == 10'd639) begin
                    ex_xa = '0;
                    ex_ya = (ex_ya == 10'd3) ? 10'd0 : ex_ya + 10'd1;
                end else begin
                    ex_xa = ex_xa + 10'd1;
                end
            end
        end
    end

    initial begin : mon_a
        logic [7:0] e;
        forever begin
            @(negedge dclk);
            if (!clr_a) begin
                if (de_a === 1'b1) begin
                    if (q_a.size() == 0) begin
                        chk("a_sb_underrun", 0, 0, 1);
                    end else begin
                        e = q_a.pop_front();
                        chk("a_sb_pixel", 0, int'({red_a, green_a, blue_a}), int'(e));
                    end
                end else begin
                    chk("a_blank_rgb", 0, int'({red_a, green_a, blue_a}), 0);
                end
            end
        end
    end

    // Pixel source b: PIPE=0, so the colour is combinational in the request cycle.
    initial begin : src_b
        {red_in_b, green_in_b, blue_in_b} = 8'hFF;
        forever begin
            @(negedge dclk);
            {red_in_b, green_in_b, blue_in_b} =
                (req_b === 1'b1) ? {x_b[2:0], y_b[2:0], x_b[1:0]} : 8'hFF;
            if (!clr_b && req_b === 1'b1) begin
                q_b.push_back({ex_xb[2:0], ex_yb[2:0], ex_xb[1:0]});
                if (ex_xb == 10'd3) begin
                    ex_xb = '0;
                    ex_yb = (ex_yb == 10'd2) ? 10'd0 : ex_yb + 10'd1;
                end else begin
                    ex_xb = ex_xb + 10'd1;
                end
            end
        end
    end

    initial begin : mon_b
        logic [7:0] e;
        forever begin
            @(negedge dclk);
            if (!clr_b) begin
                if (de_b === 1'b1) begin
                    if (q_b.size() == 0) begin
                        chk("b_sb_underrun", 0, 0, 1);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_sb_pixel", 0, int'({red_b, green_b, blue_b}), int'(e));
                    end
                end else begin
                    chk("b_blank_rgb", 0, int'({red_b, green_b, blue_b}), 0);
                end
            end
        end
    end

    // Directed timeline for instance a; n counts negedges from the first cycle after reset.
    task automatic run_a;
        clr_a = 1'b1;
        repeat (3) @(negedge dclk);
        clr_a = 1'b0;
        for (int n = 0; n <= 12500; n++) begin
            if (n > 0) @(negedge dclk);
            case (n)
                0: begin
                    chk("a_rst_fs", n, fs_a, 1);  chk("a_rst_ls", n, ls_a, 1);
                    chk("a_rst_hs", n, hs_a, 1);  chk("a_rst_vs", n, vs_a, 1);
                    chk("a_rst_de", n, de_a, 0);  chk("a_rst_red", n, red_a, 0);
                    chk("a_rst_fc", n, fc_a, 0);  chk("a_rst_req", n, req_a, 0);
                    chk("a_rst_x", n, x_a, 0);
                end
                2:     begin chk("a_hs", n, hs_a, 1); chk("a_vs", n, vs_a, 1); end
                3:     begin chk("a_hs", n, hs_a, 0); chk("a_vs", n, vs_a, 0); end
                98:    chk("a_hs", n, hs_a, 0);
                99:    chk("a_hs", n, hs_a, 1);
                800:   begin chk("a_ls", n, ls_a, 1); chk("a_fs", n, fs_a, 0); end
                801:   chk("a_ls", n, ls_a, 0);
                802:   chk("a_hs", n, hs_a, 1);
                803:   chk("a_hs", n, hs_a, 0);
                1602:  chk("a_vs", n, vs_a, 0);
                1603:  chk("a_vs", n, vs_a, 1);
                4143:  begin chk("a_req", n, req_a, 0); chk("a_x", n, x_a, 0); end
                4144:  begin chk("a_req", n, req_a, 1); chk("a_x", n, x_a, 0); chk("a_y", n, y_a, 0); end
                4146:  chk("a_de", n, de_a, 0);
                4147:  begin chk("a_de", n, de_a, 1); chk("a_red", n, red_a, 0); end
                4783:  begin chk("a_req", n, req_a, 1); chk("a_x", n, x_a, 639); end
                4784:  begin chk("a_req", n, req_a, 0); chk("a_x", n, x_a, 0); end
                4786:  begin chk("a_de", n, de_a, 1); chk("a_red", n, red_a, 7); end
                4787:  begin chk("a_de", n, de_a, 0); chk("a_red", n, red_a, 0); end
                4944:  begin chk("a_x", n, x_a, 0); chk("a_y", n, y_a, 1); end
                4948:  begin chk("a_red", n, red_a, 1); chk("a_green", n, green_a, 1); end
                7999:  begin chk("a_fc", n, fc_a, 0); chk("a_fs", n, fs_a, 0); end
                8000:  begin chk("a_fc", n, fc_a, 1); chk("a_fs", n, fs_a, 1); end
                12500: begin chk("a_x", n, x_a, 356); chk("a_y", n, y_a, 0); chk("a_de", n, de_a, 1); end
                default: ;
            endcase
        end
        // One-cycle clr pulse at hc=500, vc=5 of the second frame.
        clr_a = 1'b1;
        @(negedge dclk);
        clr_a = 1'b0;
        q_a.delete();
        ex_xa = '0;
        ex_ya = '0;
        for (int n = 0; n <= 4200; n++) begin
            if (n > 0) @(negedge dclk);
            case (n)
                0: begin
                    chk("a_pulse_fs", n, fs_a, 1); chk("a_pulse_fc", n, fc_a, 0);
                    chk("a_pulse_hs", n, hs_a, 1); chk("a_pulse_de", n, de_a, 0);
                    chk("a_pulse_red", n, red_a, 0); chk("a_pulse_x", n, x_a, 0);
                end
                1, 2: begin
                    chk("a_pulse_hs", n, hs_a, 1); chk("a_pulse_de", n, de_a, 0);
                    chk("a_pulse_rgb", n, int'({red_a, green_a, blue_a}), 0);
                end
                3:    chk("a_pulse_hs", n, hs_a, 0);
                4147: chk("a_pulse_de", n, de_a, 1);
                default: ;
            endcase
        end
        #1;
        chk("a_sb_inflight", 0, q_a.size(), 3);
    endtask

    task automatic run_b;
        clr_b = 1'b1;
        repeat (3) @(negedge dclk);
        clr_b = 1'b0;
        for (int m = 0; m <= 15365; m++) begin
            if (m > 0) @(negedge dclk);
            case (m)
                0: begin
                    chk("b_rst_fs", m, fs_b, 1); chk("b_rst_hs", m, hs_b, 0);
                    chk("b_rst_vs", m, vs_b, 0); chk("b_rst_de", m, de_b, 0);
                    chk("b_rst_fc", m, fc_b, 0);
                end
                1:  begin chk("b_hs", m, hs_b, 1); chk("b_vs", m, vs_b, 1); end
                2:  chk("b_hs", m, hs_b, 1);
                3:  chk("b_hs", m, hs_b, 0);
                10: chk("b_vs", m, vs_b, 1);
                11: begin chk("b_hs", m, hs_b, 1); chk("b_vs", m, vs_b, 0); end
                13: chk("b_hs", m, hs_b, 0);
                23: chk("b_req", m, req_b, 0);
                24: begin chk("b_req", m, req_b, 1); chk("b_x", m, x_b, 0); chk("b_de", m, de_b, 0); end
                25: begin chk("b_de", m, de_b, 1); chk("b_red", m, red_b, 0); chk("b_x", m, x_b, 1); end
                27: chk("b_x", m, x_b, 3);
                28: begin chk("b_req", m, req_b, 0); chk("b_de", m, de_b, 1); chk("b_red", m, red_b, 3); end
                29: begin chk("b_de", m, de_b, 0); chk("b_red", m, red_b, 0); end
                34: begin chk("b_x", m, x_b, 0); chk("b_y", m, y_b, 1); end
                59: chk("b_fc", m, fc_b, 0);
                60: begin chk("b_fc", m, fc_b, 1); chk("b_fs", m, fs_b, 1); end
                15299: chk("b_fc", m, fc_b, 254);
                15300: chk("b_fc", m, fc_b, 255);
                15359: chk("b_fc", m, fc_b, 255);
                15360: begin chk("b_fc_wrap", m, fc_b, 0); chk("b_fs", m, fs_b, 1); end
                default: ;
            endcase
        end
        #1;
        chk("b_sb_inflight", 0, q_b.size(), 0);
    endtask

    initial begin : main
        clr_a = 1'b1;
        clr_b = 1'b1;
        fork
            run_a();
            run_b();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the number of visible pixels per line.
REQ-002 Parameters H_SYNC 96, H_BP 48, H_FP 16 SHALL set the horizontal sync, back-porch and front-porch lengths in pixel clocks.
REQ-003 Parameters V_ACTIVE 480, V_SYNC 2, V_BP 29, V_FP 10 SHALL set the vertical timing in lines.
REQ-004 Parameter SYNC_POL, default 0, SHALL select sync polarity: 0 = active-low, 1 = active-high.
REQ-005 Parameter PIPE, default 2, range 0..4, SHALL give the pixel-source latency in cycles.
REQ-006 Parameters RW 3, GW 3, BW 2 SHALL set the colour widths; CW, default 10, SHALL set the x/y width.
REQ-007 dclk  in  1  pixel clock; the only clock.
REQ-008 clr  in  1  reset, synchronous to dclk, active-high.
REQ-009 red_in/green_in/blue_in  in  RW/GW/BW  colour for the pixel requested PIPE cycles earlier.
REQ-010 x, y  out  CW  requested pixel coordinate; 0 when req_active=0.
REQ-011 req_active  out  1  the current counter position is visible.
REQ-012 frame_start, line_start  out  1  single-cycle pulses at hc=0,vc=0 and at hc=0.
REQ-013 hsync, vsync, de  out  1  syncs and display enable, aligned with the colour outputs.
REQ-014 red/green/blue  out  RW/GW/BW  registered colour outputs.
REQ-015 frame_cnt  out  8  completed-frame counter.

Function
REQ-016 HT=H_SYNC+H_BP+H_ACTIVE+H_FP and VT=V_SYNC+V_BP+V_ACTIVE+V_FP SHALL hold (defaults 800 and 521).
REQ-017 Counter hc SHALL count 0..HT-1 and wrap to 0.
REQ-018 Counter vc SHALL increment only on the cycle hc wraps, and SHALL wrap from VT-1 to 0.
REQ-019 Line order SHALL be sync, back porch, active, front porch, so hsync is asserted for hc<H_SYNC.
REQ-020 req_active SHALL be 1 iff H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vc < V_SYNC+V_BP+V_ACTIVE.
REQ-021 When req_active=1, x=hc-(H_SYNC+H_BP) and y=vc-(V_SYNC+V_BP), with no truncation.
REQ-022 x, y, req_active, frame_start and line_start SHALL be decoded from the hc/vc registers in the same cycle, with no extra register stage.
REQ-023 Raw hsync, vsync and de SHALL pass through a PIPE+1 stage delay line, so that outputs appear PIPE+1 cycles after their counter position.
REQ-024 Colour outputs SHALL register red_in/green_in/blue_in when the de delayed by PIPE stages is 1, else register 0.
REQ-025 Outputs SHALL therefore be blanked to 0 whenever de=0, regardless of the inputs.
REQ-026 Sync outputs SHALL equal SYNC_POL when asserted and ~SYNC_POL when deasserted.
REQ-027 frame_cnt SHALL increment, modulo 256, on the cycle hc=HT-1 and vc=VT-1.
REQ-028 frame_cnt SHALL wrap from 255 to 0.

Reset
REQ-029 While clr=1 at a dclk edge, the block SHALL set hc=0, vc=0 and frame_cnt=0.
REQ-030 While clr=1 at a dclk edge, the block SHALL clear every delay-line stage to deasserted sync (~SYNC_POL) and de=0, and colours to 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; the first cycle after clr falls SHALL have hc=0, vc=0 and frame_start=1.
REQ-032 During the first PIPE+1 cycles after reset, hsync/vsync SHALL stay deasserted, de=0 and colours 0.
REQ-033 hsync SHALL first assert PIPE+1 cycles after reset release.

Verification
REQ-034 Defaults, clr released at T0 -> hsync low during T0+3..T0+98, period 800 cycles; vsync low for 1600 cycles; frame period 416800 cycles.
REQ-035 Defaults -> req_active first at hc=144,vc=31 with x=0,y=0; de high 640 cycles per line on 480 lines, starting 3 cycles after req_active.
REQ-036 Source model red_in=x[2:0] delayed 2 cycles, plus red_in=3'b111 forced during blanking -> red equals x[2:0] of the pixel requested 3 cycles earlier; red=0 whenever de=0.
REQ-037 clr pulsed 1 cycle at hc=500,vc=200 -> next cycle hc=0, vc=0, frame_start=1, frame_cnt=0; hsync=1, de=0, colours 0 for 3 cycles.
REQ-038 SYNC_POL=1, PIPE=0, H 4/2/2/2, V 3/1/1/1 -> hsync high for 2 of 10 cycles; output latency 1 cycle; x counts 0..3; frame_cnt wraps 255->0 after 256 frames of 60 cycles.
